seven_seg_scan_driver: RTL and testbench

//   Time-multiplexed scan driver for the two-digit common-cathode 7-segment

---
 rtl/seven_seg_scan_driver_if.sv | 23 ++
 rtl/seven_seg_scan_driver.sv | 108 ++++++++++
 tb/tb_seven_seg_scan_driver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Signal bundle between the two-digit scan driver and its pattern source / display pins.
// The master supplies patterns and enable; the slave (driver) returns the scanned bus and a frame strobe.
interface seven_seg_scan_driver_if;
    logic       i_EN;
    logic [6:0] i_SEG0;
    logic [6:0] i_SEG1;
    logic       i_BLANK1;
    logic [6:0] o_SEG;
    logic       o_CA;
    logic       o_FRAME;
    logic       dbg_slot;

    // o_FRAME is a one-cycle strobe with no back-pressure: i_SEG0/i_SEG1/i_BLANK1
    // are sampled on the edge that closes the cycle where o_FRAME is high.
    modport master (
        output i_EN, i_SEG0, i_SEG1, i_BLANK1,
        input  o_SEG, o_CA, o_FRAME, dbg_slot
    );
    modport slave (
        input  i_EN, i_SEG0, i_SEG1, i_BLANK1,
        output o_SEG, o_CA, o_FRAME, dbg_slot
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Two-digit multiplexed 7-segment scan driver with per-frame shadow latching and
// a blanking dead-time at the start of each digit slot. All outputs come from flops.
module seven_seg_scan_driver #(
    parameter int SCAN_DIV     = 6000,
    parameter int BLANK_CYCLES = 120,
    parameter bit SEG_ACT_LOW  = 1'b0
) (
    input  logic                    CLK,
    input  logic                    i_RST_N,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]     SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;

    typedef enum logic {SLOT0 = 1'b0, SLOT1 = 1'b1} slot_e;

    logic [1:0]    sync_q;
    logic          run;
    slot_e         slot_q, slot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    sh0_q, sh0_d, sh1_q, sh1_d;
    logic          shb_q, shb_d;
    logic [6:0]    seg_q, seg_d;
    logic          ca_q, ca_d;
    logic          frame_q, frame_d;
    logic          active;
    logic [6:0]    lit;

    // Reset asserts asynchronously but the scan only starts two clocks after release.
    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end
    assign run = sync_q[1];

    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            slot_q  <= SLOT0;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            shb_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            ca_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            shb_q   <= shb_d;
            seg_q   <= seg_d;
            ca_q    <= ca_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        sh0_d  = sh0_q;
        sh1_d  = sh1_q;
        shb_d  = shb_q;
        lit    = 7'h00;
        active = run && bus.i_EN;

        if (!run) begin
            slot_d = SLOT0;
            cnt_d  = '0;
            sh0_d  = '0;
            sh1_d  = '0;
            shb_d  = 1'b0;
        end else if (!bus.i_EN) begin
            // Parked: shadows track the inputs so re-enable shows live values at once.
            slot_d = SLOT0;
            cnt_d  = '0;
            sh0_d  = bus.i_SEG0;
            sh1_d  = bus.i_SEG1;
            shb_d  = bus.i_BLANK1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = (slot_q == SLOT0) ? SLOT1 : SLOT0;
            if (slot_q == SLOT1) begin
                sh0_d = bus.i_SEG0;
                sh1_d = bus.i_SEG1;
                shb_d = bus.i_BLANK1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are computed from the next position so they line up with slot/cnt.
        if (active && (cnt_d >= CNT_BLANK)) begin
            if (slot_d == SLOT0)  lit = sh0_d;
            else if (!shb_d)      lit = sh1_d;
        end
        seg_d   = lit ^ {7{SEG_ACT_LOW}};
        ca_d    = active && (slot_d == SLOT1);
        frame_d = active && (slot_d == SLOT1) && (cnt_d == CNT_LAST);
    end

    assign bus.o_SEG    = seg_q;
    assign bus.o_CA     = ca_q;
    assign bus.o_FRAME  = frame_q;
    assign bus.dbg_slot = slot_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomised self-checking bench for seven_seg_scan_driver: an active-high and an
// active-low instance share stimulus and are compared each cycle with a frame-position model.
`timescale 1ns/1ps
module tb_seven_seg_scan_driver;
    localparam int D = 8;
    localparam int B = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [6:0] seg0, seg1;
    logic       blank1;
    logic       chk_on;
    int         n_chk;
    int         n_fail;

    seven_seg_scan_driver_if bus_a();
    seven_seg_scan_driver_if bus_b();

    assign bus_a.i_EN = en;     assign bus_b.i_EN = en;
    assign bus_a.i_SEG0 = seg0; assign bus_b.i_SEG0 = seg0;
    assign bus_a.i_SEG1 = seg1; assign bus_b.i_SEG1 = seg1;
    assign bus_a.i_BLANK1 = blank1; assign bus_b.i_BLANK1 = blank1;

    seven_seg_scan_driver #(.SCAN_DIV(D), .BLANK_CYCLES(B), .SEG_ACT_LOW(1'b0)) dut_a (
        .CLK(clk), .i_RST_N(rst_n), .bus(bus_a));
    seven_seg_scan_driver #(.SCAN_DIV(D), .BLANK_CYCLES(B), .SEG_ACT_LOW(1'b1)) dut_b (
        .CLK(clk), .i_RST_N(rst_n), .bus(bus_b));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // pos is the position within a 2*D frame; rel counts clocks since reset release.
    int         pos, rel;
    logic [6:0] m_sh0, m_sh1, m_seg;
    logic       m_shb, m_ca, m_fr;

    initial begin
        pos = 0; rel = 0; m_sh0 = 0; m_sh1 = 0; m_shb = 0; m_seg = 0; m_ca = 0; m_fr = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pos = 0; rel = 0; m_sh0 = 0; m_sh1 = 0; m_shb = 0;
                m_seg = 0; m_ca = 0; m_fr = 0;
            end else if (rel < 2) begin
                rel++;
                pos = 0; m_seg = 0; m_ca = 0; m_fr = 0;
            end else if (!en) begin
                pos = 0; m_sh0 = seg0; m_sh1 = seg1; m_shb = blank1;
                m_seg = 0; m_ca = 0; m_fr = 0;
            end else begin
                if (pos == 2*D-1) begin
                    m_sh0 = seg0; m_sh1 = seg1; m_shb = blank1;
                end
                pos   = (pos + 1) % (2*D);
                m_ca  = (pos >= D);
                m_fr  = (pos == 2*D-1);
                if ((pos % D) < B) m_seg = 7'h00;
                else if (pos < D)  m_seg = m_sh0;
                else               m_seg = m_shb ? 7'h00 : m_sh1;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("seg_a", bus_a.o_SEG, m_seg);
                chk("seg_b", bus_b.o_SEG, ~m_seg);
                chk("ca_a", {6'b0, bus_a.o_CA}, {6'b0, m_ca});
                chk("ca_b", {6'b0, bus_b.o_CA}, {6'b0, m_ca});
                chk("frame_a", {6'b0, bus_a.o_FRAME}, {6'b0, m_fr});
                chk("frame_b", {6'b0, bus_b.o_FRAME}, {6'b0, m_fr});
                chk("dbg_slot", {6'b0, bus_a.dbg_slot}, {6'b0, m_ca});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg_a", bus_a.o_SEG, 7'h00);
        chk("async_seg_b", bus_b.o_SEG, 7'h7F);
        chk("async_ca", {6'b0, bus_a.o_CA}, 7'h00);
        chk("async_frame", {6'b0, bus_a.o_FRAME}, 7'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [6:0] cap_a [32];
    logic [6:0] cap_b [32];
    logic       cap_ca [32];
    logic       cap_fr [32];
    logic [6:0] lit_f2 [16];
    logic [6:0] or_f1;
    int         off_left;

    initial begin
        lit_f2 = '{7'h00, 7'h00, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06,
                   7'h00, 7'h00, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B};
        n_chk = 0; n_fail = 0; chk_on = 1'b0;
        rst_n = 1'b0; en = 1'b1; seg0 = 7'h06; seg1 = 7'h5B; blank1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg_a", bus_a.o_SEG, 7'h00);
        chk("rst_seg_b", bus_b.o_SEG, 7'h7F);
        chk("rst_ca", {6'b0, bus_a.o_CA}, 7'h00);
        chk("rst_frame", {6'b0, bus_a.o_FRAME}, 7'h00);
        chk_on = 1'b1;
        rst_n  = 1'b1;

        // Two sync clocks, then the first counting clock moves to cycle 1.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 1; k < 32; k++) begin
            cap_a[k]  = bus_a.o_SEG;
            cap_b[k]  = bus_b.o_SEG;
            cap_ca[k] = bus_a.o_CA;
            cap_fr[k] = bus_a.o_FRAME;
            @(negedge clk);
        end
        or_f1 = 7'h00;
        for (int k = 1; k < 16; k++) or_f1 = or_f1 | cap_a[k];
        chk("frame1_dark", or_f1, 7'h00);
        chk("ca_c7", {6'b0, cap_ca[7]}, 7'h00);
        chk("ca_c8", {6'b0, cap_ca[8]}, 7'h01);
        chk("ca_c15", {6'b0, cap_ca[15]}, 7'h01);
        chk("ca_c17", {6'b0, cap_ca[17]}, 7'h00);
        chk("frame_c14", {6'b0, cap_fr[14]}, 7'h00);
        chk("frame_c15", {6'b0, cap_fr[15]}, 7'h01);
        chk("frame_c31", {6'b0, cap_fr[31]}, 7'h01);
        for (int i = 1; i < 16; i++) chk("frame2_seg", cap_a[16+i], lit_f2[i]);
        chk("actlow_blank", cap_b[17], 7'h7F);
        chk("actlow_lit0", cap_b[18], 7'h79);
        chk("actlow_lit1", cap_b[26], 7'h24);

        // Directed: mid-slot-1 pattern change, blank1, enable gap, async reset.
        repeat (10) @(negedge clk);
        seg0 = 7'h3F;
        repeat (2) @(negedge clk);
        blank1 = 1'b1;
        repeat (30) @(negedge clk);
        blank1 = 1'b0;
        repeat (11) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        seg0 = 7'h66;
        en = 1'b1;
        repeat (13) @(negedge clk);
        async_reset_pulse();
        repeat (40) @(negedge clk);

        // Random phase.
        off_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) seg0 = 7'($urandom);
            if ($urandom_range(0, 11) == 0) seg1 = 7'($urandom);
            if ($urandom_range(0, 39) == 0) blank1 = ~blank1;
            if (off_left > 0) begin
                off_left--;
                en = (off_left == 0);
            end else if ($urandom_range(0, 99) == 0) begin
                off_left = $urandom_range(1, 6);
                en = 1'b0;
            end
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
            else @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
